stopwatch_core: RTL and testbench

//  MM:SS stopwatch for the Basys3 display path: divides the system clock to a 1 Hz tick
//  (4 Hz with speed_up) and counts BCD seconds/minutes 00:00..59:59 with wrap.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_core_bcd_digit_counter.sv | 32 +++
 rtl/stopwatch_core.sv | 99 +++++++++
 tb/tb_stopwatch_core.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the MM:SS stopwatch.
// Digit maxima plus default clock and speed-up constants.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_UNITS_MAX = 9;
  localparam int SEC_TENS_MAX  = 5;
  localparam int MIN_UNITS_MAX = 9;
  localparam int MIN_TENS_MAX  = 5;

  localparam int DEF_CLK_FREQ_HZ    = 100_000_000;
  localparam int DEF_SPEEDUP_FACTOR = 4;

endpackage

// File: rtl/stopwatch_core_bcd_digit_counter.sv
// One BCD digit that wraps at MAX.
// carry flags the increment that wraps it back to zero.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output bcd_t value,
  output logic carry
);

  localparam bcd_t MAX_V = bcd_t'(MAX);

  assign carry = inc && (value == MAX_V);

  // advance on inc, wrap to zero after MAX
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (inc) begin
      if (value == MAX_V) begin
        value <= '0;
      end else begin
        value <= value + bcd_t'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: clock divider to a one-cycle tick, four BCD digits.
// Define STOPWATCH_PAUSE_EN to add the pause input.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
  parameter int SPEEDUP_FACTOR = DEF_SPEEDUP_FACTOR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       speed_up,
`ifdef STOPWATCH_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3
);

  localparam int DW = $clog2(CLK_FREQ_HZ);
  localparam int FAST_HZ = CLK_FREQ_HZ / SPEEDUP_FACTOR;

  localparam logic [DW-1:0] TERM_SLOW =
    DW'(CLK_FREQ_HZ - 1);
  localparam logic [DW-1:0] TERM_FAST =
    DW'(FAST_HZ - 1);

  logic [DW-1:0] clk_div;
  logic          tick;
  logic          run;
  logic [DW-1:0] term_m1;
  logic          adv;
  logic          c0, c1, c2, c3;
  bcd_t          v0, v1, v2, v3;

`ifdef STOPWATCH_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif

  assign term_m1 = speed_up ? TERM_FAST : TERM_SLOW;
  assign adv     = tick && run;

  // divider: >= lets a lowered terminal recover at once
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_div <= '0;
      tick    <= 1'b0;
    end else if (!run) begin
      tick    <= 1'b0;
    end else if (clk_div >= term_m1) begin
      clk_div <= '0;
      tick    <= 1'b1;
    end else begin
      clk_div <= clk_div + DW'(1);
      tick    <= 1'b0;
    end
  end

  bcd_digit_counter #(.MAX(SEC_UNITS_MAX)) u_sec_units (
    .clk   (clk),
    .reset (reset),
    .inc   (adv),
    .value (v0),
    .carry (c0)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk   (clk),
    .reset (reset),
    .inc   (c0),
    .value (v1),
    .carry (c1)
  );

  bcd_digit_counter #(.MAX(MIN_UNITS_MAX)) u_min_units (
    .clk   (clk),
    .reset (reset),
    .inc   (c1),
    .value (v2),
    .carry (c2)
  );

  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk   (clk),
    .reset (reset),
    .inc   (c2),
    .value (v3),
    .carry (c3)
  );

  assign digit0 = v0;
  assign digit1 = v1;
  assign digit2 = v2;
  assign digit3 = v3;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core at CLK_FREQ_HZ=8, x4.
// Reference model counts elapsed seconds as a plain integer.
module tb_stopwatch_core;

  localparam int F  = 8;
  localparam int SF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       speed_up = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;

  int vectors = 0;
  int errors  = 0;

  int m_div  = 0;
  int m_tick = 0;
  int m_secs = 0;

  always #5 clk = ~clk;

  stopwatch_core #(
    .CLK_FREQ_HZ    (F),
    .SPEEDUP_FACTOR (SF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .speed_up (speed_up),
`ifdef STOPWATCH_PAUSE_EN
    .pause    (pause),
`endif
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3)
  );

  function automatic logic [15:0] exp_digits();
    int mm, ss;
    mm = m_secs / 60;
    ss = m_secs % 60;
    return {4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] act_digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // one clock: drive inputs, advance model, settle to negedge
  task automatic step(input logic r, input logic sp,
                      input logic pz);
    int term;
    reset    = r;
    speed_up = sp;
    pause    = pz;
    @(posedge clk);
    if (r) begin
      m_div = 0; m_tick = 0; m_secs = 0;
    end else if (pz) begin
      m_tick = 0;
    end else begin
      if (m_tick == 1) m_secs = (m_secs + 1) % 3600;
      term = sp ? F / SF : F;
      if (m_div >= term - 1) begin
        m_div = 0; m_tick = 1;
      end else begin
        m_div = m_div + 1; m_tick = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    vectors++;
    if (act_digits() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_digits got %h want 0000",
               act_digits());
    end
    vectors++;
    if (int'(dut.clk_div) !== 0 || dut.tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_div got div=%0d tick=%b want 0/0",
               dut.clk_div, dut.tick);
    end
  endtask

  task automatic test_count_10();
    int n = 0;
    while (m_secs != 10 && n < 200) begin
      step(0, 0, 0);
      n++;
      vectors++;
      if (act_digits() !== exp_digits()) begin
        errors++;
        $display("FAIL count10 got %h want %h",
                 act_digits(), exp_digits());
      end
    end
    vectors++;
    if (act_digits() !== 16'h0010) begin
      errors++;
      $display("FAIL at_00_10 got %h want 0010",
               act_digits());
    end
  endtask

  task automatic test_minute_carry();
    int n = 0;
    while (m_secs != 60 && n < 1000) begin
      step(0, 1, 0);
      n++;
      vectors++;
      if (act_digits() !== exp_digits()) begin
        errors++;
        $display("FAIL minute got %h want %h",
                 act_digits(), exp_digits());
      end
    end
    vectors++;
    if (act_digits() !== 16'h0100) begin
      errors++;
      $display("FAIL at_01_00 got %h want 0100",
               act_digits());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    step(1, 1, 0);
    vectors++;
    if (act_digits() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_first got %h want 0000",
               act_digits());
    end
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    vectors++;
    if (act_digits() !== 16'h0000 ||
        int'(dut.clk_div) !== 0) begin
      errors++;
      $display("FAIL reset_mid_hold got %h div=%0d want 0000/0",
               act_digits(), dut.clk_div);
    end
  endtask

  task automatic test_full_wrap();
    int n = 0;
    step(1, 1, 0);
    while (m_secs != 3599 && n < 20000) begin
      step(0, 1, 0);
      n++;
      if (act_digits() !== exp_digits()) begin
        vectors++;
        errors++;
        $display("FAIL wrap_run got %h want %h",
                 act_digits(), exp_digits());
      end
    end
    vectors++;
    if (act_digits() !== 16'h5959) begin
      errors++;
      $display("FAIL at_59_59 got %h want 5959",
               act_digits());
    end
    n = 0;
    while (m_secs != 0 && n < 20) begin
      step(0, 1, 0);
      n++;
    end
    vectors++;
    if (act_digits() !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_00_00 got %h want 0000",
               act_digits());
    end
  endtask

  task automatic test_speed();
    int last, gap;
    for (int s = 0; s < 2; s++) begin
      step(1, 1'(s), 0);
      last = -1;
      for (int c = 1; c <= 40; c++) begin
        step(0, 1'(s), 0);
        vectors++;
        if (dut.tick !== 1'(m_tick)) begin
          errors++;
          $display("FAIL tick_sp%0d c%0d got %b want %0d",
                   s, c, dut.tick, m_tick);
        end
        if (dut.tick === 1'b1) begin
          gap = c - last;
          vectors++;
          if (last >= 0 && gap !== (s ? F / SF : F)) begin
            errors++;
            $display("FAIL period_sp%0d got %0d want %0d",
                     s, gap, s ? F / SF : F);
          end
          last = c;
        end
      end
    end
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    vectors++;
    if (int'(dut.clk_div) !== 5) begin
      errors++;
      $display("FAIL switch_pre got div=%0d want 5",
               dut.clk_div);
    end
    step(0, 1, 0);
    vectors++;
    if (dut.tick !== 1'b1 || int'(dut.clk_div) !== 0) begin
      errors++;
      $display("FAIL switch got tick=%b div=%0d want 1/0",
               dut.tick, dut.clk_div);
    end
  endtask

`ifdef STOPWATCH_PAUSE_EN
  task automatic test_pause();
    int n = 0;
    logic [15:0] d0;
    int dv;
    step(1, 0, 0);
    while (m_secs != 7 && n < 200) begin
      step(0, 0, 0);
      n++;
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    d0 = act_digits();
    dv = int'(dut.clk_div);
    vectors++;
    if (d0 !== 16'h0007) begin
      errors++;
      $display("FAIL pause_pre got %h want 0007", d0);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1);
      vectors++;
      if (act_digits() !== d0 ||
          int'(dut.clk_div) !== dv ||
          dut.tick !== 1'b0) begin
        errors++;
        $display("FAIL pause got %h div=%0d want %h div=%0d",
                 act_digits(), dut.clk_div, d0, dv);
      end
    end
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0);
      vectors++;
      if (act_digits() !== exp_digits()) begin
        errors++;
        $display("FAIL resume got %h want %h",
                 act_digits(), exp_digits());
      end
    end
  endtask
`endif

  task automatic test_random();
    logic r, sp, pz;
    sp = 0;
    step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) sp = ~sp;
`ifdef STOPWATCH_PAUSE_EN
      pz = ($urandom_range(0, 7) == 0);
`else
      pz = 1'b0;
`endif
      step(r, sp, pz);
      vectors++;
      if (act_digits() !== exp_digits() ||
          int'(dut.clk_div) !== m_div ||
          dut.tick !== 1'(m_tick)) begin
        errors++;
        $display("FAIL random i%0d got %h/%0d/%b want %h/%0d/%0d",
                 i, act_digits(), dut.clk_div, dut.tick,
                 exp_digits(), m_div, m_tick);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_10();
    test_minute_carry();
    test_reset_mid();
    test_full_wrap();
    test_speed();
`ifdef STOPWATCH_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
